mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch port (IF) and the data port (MEM stage).
- Sequences one memory transaction at a time.
- Produces per-port stall signals that feed the PCWrite and pipeline-register write enables.
- Data accesses normally win arbitration; a starvation counter guarantees forward progress for fetch.
- Supports killing an in-flight fetch on a branch flush.

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch port and the data port. One transaction is in flight at a
// time. Data accesses normally win; a starvation counter forces a fetch grant
// after MAX_IF_WAIT consecutive data grants with a fetch pending. A fetch can be
// killed (branch flush) at any point; the memory transaction still completes,
// only the completion pulse towards the fetch port is suppressed.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    // pipeline stalls
    output logic              stall_if,
    output logic              stall_mem,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_IF_WAIT);
    localparam logic [3:0] STARVE_SAT   = 4'hF;

    state_t            state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              kill_q,      kill_d;
    logic [3:0]        starve_q,    starve_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    // A fetch that is being killed this very cycle is not a request.
    logic if_req_eff;
    logic grant_if;
    logic grant_d;

    assign if_req_eff = if_req & ~if_kill;

    // Arbitration decision, only meaningful in IDLE.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == S_IDLE) begin
            grant_if = if_req_eff & (~d_req | (starve_q == STARVE_LIMIT));
            grant_d  = d_req & ~grant_if;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            kill_q      <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            kill_q      <= kill_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (grant_if) begin
                    owner_d     = OWN_IF;
                    state_d     = S_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = 4'd0;
                end else if (grant_d) begin
                    owner_d     = OWN_D;
                    state_d     = S_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Count data grants that overtook a waiting fetch.
                    if (if_req_eff && (starve_q != STARVE_SAT)) begin
                        starve_d = starve_q + 4'd1;
                    end else if (!if_req) begin
                        starve_d = 4'd0;
                    end
                end else if (!if_req) begin
                    starve_d = 4'd0;
                end
            end

            S_REQ: begin
                // The request stays up even when the fetch is killed.
                if (if_kill && (owner_q == OWN_IF)) begin
                    kill_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (if_kill && (owner_q == OWN_IF)) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // The completion cycle consumes any pending kill.
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completion pulses are decoded from registered state only.
    always_comb begin
        if_done = 1'b0;
        d_done  = 1'b0;
        if (state_q == S_DONE) begin
            if (owner_q == OWN_IF) begin
                if_done = ~kill_q;
            end else begin
                d_done = 1'b1;
            end
        end
    end

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req & ~d_done;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a bench-side memory responder checks every
// grant against a queue of expected grants, and a monitor checks every
// completion pulse against queues of expected read data.
module tb_mem_port_arbiter;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        if_req     = 1'b0;
    logic [31:0] if_addr    = 32'h0;
    logic        if_kill    = 1'b0;
    logic        d_req      = 1'b0;
    logic        d_we       = 1'b0;
    logic [31:0] d_addr     = 32'h0;
    logic [31:0] d_wdata    = 32'h0;
    logic        mem_ready  = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'h0;

    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, stall_if, stall_mem, mem_req, mem_we;

    int total = 0;
    int bad   = 0;

    // bench memory model and scoreboards
    logic [31:0] store_mem [logic [31:0]];
    logic [32:0] exp_grant_q[$];   // {we, addr}
    logic [31:0] exp_if_q[$];      // fetch data
    logic [32:0] exp_d_q[$];       // {check_data, data}
    int          rdy_delay   = 0;
    int          rv_delay    = 1;
    int          rdy_cnt     = 0;
    int          rv_cnt      = 0;
    int          completions = 0;
    bit          stray_rv    = 1'b0;
    logic [31:0] pend_data   = 32'h0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_IF_WAIT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (store_mem.exists(a)) return store_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // Memory responder: accepts after rdy_delay cycles, completes rv_delay cycles later.
    always @(negedge clk) begin
        logic [32:0] g;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (rst) begin
            rdy_cnt = 0;
            rv_cnt  = 0;
        end else begin
            if (stray_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_0BAD;
                stray_rv   = 1'b0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                    completions++;
                end
            end
            if (mem_req) begin
                if (rdy_cnt >= rdy_delay) begin
                    mem_ready = 1'b1;
                    rdy_cnt   = 0;
                    rv_cnt    = rv_delay;
                    if (mem_we) begin
                        store_mem[mem_addr] = mem_wdata;
                        pend_data = 32'h0;
                    end else begin
                        pend_data = mem_read(mem_addr);
                    end
                    total++;
                    if (exp_grant_q.size() == 0) begin
                        bad++;
                        $display("FAIL grant_unexpected: got we=%0b addr=%h, required no grant", mem_we, mem_addr);
                    end else begin
                        g = exp_grant_q.pop_front();
                        if ({mem_we, mem_addr} !== g) begin
                            bad++;
                            $display("FAIL grant_order: got we=%0b addr=%h, required we=%0b addr=%h",
                                     mem_we, mem_addr, g[32], g[31:0]);
                        end
                    end
                end else begin
                    rdy_cnt++;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [32:0] ed;
        if (!rst && if_done) begin
            total++;
            if (exp_if_q.size() == 0) begin
                bad++;
                $display("FAIL if_done_unexpected: got if_rdata=%h, required no completion", if_rdata);
            end else begin
                e = exp_if_q.pop_front();
                $display("fetch done: if_rdata=%h expected=%h", if_rdata, e);
                if (if_rdata !== e) begin
                    bad++;
                    $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
                end
            end
        end
        if (!rst && d_done) begin
            total++;
            if (exp_d_q.size() == 0) begin
                bad++;
                $display("FAIL d_done_unexpected: got d_rdata=%h, required no completion", d_rdata);
            end else begin
                ed = exp_d_q.pop_front();
                $display("data done: d_rdata=%h expected=%h check=%0b", d_rdata, ed[31:0], ed[32]);
                if (ed[32] && (d_rdata !== ed[31:0])) begin
                    bad++;
                    $display("FAIL d_rdata: got %h, required %h", d_rdata, ed[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_req, mem_we, if_done, d_done, stall_if, stall_mem} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {mem_req, mem_we, if_done, d_done, stall_if, stall_mem});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_mem_fields: got addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
        end
        total++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got if=%h d=%h, required 0", if_rdata, d_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        exp_grant_q.push_back({1'b0, 32'h40});
        exp_if_q.push_back(32'h0050_0093);
        if_addr = 32'h40;
        if_req  = 1'b1;
        #1;
        total++;
        if (stall_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_c0: got %b, required 1", stall_if); end
        @(negedge clk);  // cycle 1
        total++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            bad++;
            $display("FAIL fetch_mem_c1: got req=%b we=%b addr=%h, required req=1 we=0 addr=00000040",
                     mem_req, mem_we, mem_addr);
        end
        total++;
        if (stall_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_c1: got %b, required 1", stall_if); end
        @(negedge clk);  // cycle 2
        total++;
        if ({mem_req, if_done, stall_if} !== 3'b001) begin
            bad++;
            $display("FAIL fetch_c2: got req/done/stall=%b, required 001", {mem_req, if_done, stall_if});
        end
        @(negedge clk);  // cycle 3
        total++;
        if ({if_done, if_rdata} !== {1'b1, 32'h0050_0093}) begin
            bad++;
            $display("FAIL fetch_done_c3: got done=%b data=%h, required done=1 data=00500093", if_done, if_rdata);
        end
        total++;
        if (stall_if !== 1'b0) begin bad++; $display("FAIL fetch_stall_c3: got %b, required 0", stall_if); end
        if_req = 1'b0;
        @(negedge clk);  // cycle 4
        total++;
        if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_done_c4: got %b, required 0", if_done); end
    endtask

    task automatic test_store();
        int req_cycles = 0;
        int unstable   = 0;
        int dones      = 0;
        bit got        = 1'b0;
        rdy_delay = 3;
        exp_grant_q.push_back({1'b1, 32'h100});
        exp_d_q.push_back({1'b0, 32'h0});
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        d_req   = 1'b1;
        #1;
        total++;
        if (stall_mem !== 1'b1) begin bad++; $display("FAIL store_stall: got %b, required 1", stall_mem); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) unstable++;
            end
            if (d_done) begin
                dones++;
                d_req = 1'b0;
            end
        end
        rdy_delay = 0;
        total++;
        if (req_cycles != 4) begin bad++; $display("FAIL store_req_cycles: got %0d, required 4", req_cycles); end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL store_fields: got %0d unstable cycles, required 0", unstable); end
        total++;
        if (dones != 1) begin bad++; $display("FAIL store_done_count: got %0d, required 1", dones); end

        // read the stored word back through the data port
        exp_grant_q.push_back({1'b0, 32'h100});
        exp_d_q.push_back({1'b1, 32'hDEAD_BEEF});
        d_we  = 1'b0;
        d_req = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (d_done) begin
                got = 1'b1;
                d_req = 1'b0;
                total++;
                if (d_rdata !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL load_back: got %h, required deadbeef", d_rdata);
                end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL load_back_timeout: got no d_done, required one"); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int nif = 0;
        int nd  = 0;
        exp_grant_q.push_back({1'b0, 32'h800});
        exp_grant_q.push_back({1'b0, 32'h804});
        exp_grant_q.push_back({1'b0, 32'h808});
        exp_grant_q.push_back({1'b0, 32'h200});
        exp_grant_q.push_back({1'b0, 32'h80C});
        exp_grant_q.push_back({1'b0, 32'h810});
        exp_grant_q.push_back({1'b0, 32'h814});
        exp_grant_q.push_back({1'b0, 32'h204});
        if_addr = 32'h200;
        exp_if_q.push_back(mem_read(32'h200));
        d_we   = 1'b0;
        d_addr = 32'h800;
        exp_d_q.push_back({1'b1, mem_read(32'h800)});
        if_req = 1'b1;
        d_req  = 1'b1;
        for (int c = 0; c < 80 && (nif < 2 || nd < 6); c++) begin
            @(negedge clk);
            if (if_done) begin
                nif++;
                total++;
                if (dut.starve_q !== 4'd0) begin
                    bad++;
                    $display("FAIL starve_clear: got %0d, required 0", dut.starve_q);
                end
                if (nif < 2) begin
                    if_addr = 32'h200 + 32'(4 * nif);
                    exp_if_q.push_back(mem_read(if_addr));
                end else begin
                    if_req = 1'b0;
                end
            end
            if (d_done) begin
                nd++;
                if (nd < 6) begin
                    d_addr = 32'h800 + 32'(4 * nd);
                    exp_d_q.push_back({1'b1, mem_read(d_addr)});
                end else begin
                    d_req = 1'b0;
                end
            end
        end
        total++;
        if (nif != 2 || nd != 6) begin
            bad++;
            $display("FAIL starve_progress: got if=%0d d=%0d, required if=2 d=6", nif, nd);
        end
        total++;
        if (exp_grant_q.size() != 0) begin
            bad++;
            $display("FAIL starve_grants_left: got %0d, required 0", exp_grant_q.size());
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_kill_wait();
        int base_comp;
        int kdone = 0;
        bit got   = 1'b0;
        rv_delay  = 3;
        base_comp = completions;
        exp_grant_q.push_back({1'b0, 32'h300});
        if_addr = 32'h300;
        if_req  = 1'b1;
        @(negedge clk);  // REQ
        @(negedge clk);  // WAIT
        if_kill = 1'b1;
        if_req  = 1'b0;
        @(negedge clk);
        if_kill = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if_done) kdone++;
        end
        rv_delay = 1;
        total++;
        if (kdone != 0) begin bad++; $display("FAIL kill_done: got %0d pulses, required 0", kdone); end
        total++;
        if (completions != base_comp + 1) begin
            bad++;
            $display("FAIL kill_mem_complete: got %0d completions, required %0d", completions - base_comp, 1);
        end
        total++;
        if (exp_grant_q.size() != 0) begin
            bad++;
            $display("FAIL kill_grant: got %0d pending grants, required 0", exp_grant_q.size());
        end
        // next fetch must go through normally with minimum latency
        exp_grant_q.push_back({1'b0, 32'h304});
        exp_if_q.push_back(mem_read(32'h304));
        if_addr = 32'h304;
        if_req  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if_done) got = 1'b1;
        end
        total++;
        if (!got || if_rdata !== mem_read(32'h304)) begin
            bad++;
            $display("FAIL kill_next_fetch: got done=%b data=%h, required done=1 data=%h",
                     got, if_rdata, mem_read(32'h304));
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_kill_idle();
        if_addr = 32'h500;
        if_req  = 1'b1;
        if_kill = 1'b1;
        d_req   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mem_req !== 1'b0) begin bad++; $display("FAIL kill_idle_c%0d: got mem_req=%b, required 0", c, mem_req); end
        end
        if_req  = 1'b0;
        if_kill = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rv_delay = 4;
        exp_grant_q.push_back({1'b0, 32'h40});
        if_addr = 32'h40;
        if_req  = 1'b1;
        @(negedge clk);  // REQ
        @(negedge clk);  // WAIT
        #2 rst = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we, if_done, d_done} !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid_ctrl: got %b, required 0000", {mem_req, mem_we, if_done, d_done});
        end
        total++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            bad++;
            $display("FAIL rst_mid_data: got addr=%h if_rdata=%h d_rdata=%h, required 0", mem_addr, if_rdata, d_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        rv_delay = 1;
        stray_rv = 1'b1;
        @(negedge clk);  // stray rvalid driven here
        @(negedge clk);
        total++;
        if ({if_done, d_done, mem_req} !== 3'b0 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL stray_rvalid: got done/done/req=%b if_rdata=%h, required 000 and 0",
                     {if_done, d_done, mem_req}, if_rdata);
        end
        exp_grant_q.push_back({1'b0, 32'h40});
        exp_if_q.push_back(32'h0050_0093);
        if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({if_done, if_rdata} !== {1'b1, 32'h0050_0093}) begin
            bad++;
            $display("FAIL rst_refetch: got done=%b data=%h, required done=1 data=00500093", if_done, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        store_mem[32'h40] = 32'h0050_0093;
        test_reset();
        test_single_fetch();
        test_store();
        test_starvation();
        test_kill_wait();
        test_kill_idle();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (exp_grant_q.size() != 0 || exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got grant=%0d if=%0d d=%0d left, required 0",
                     exp_grant_q.size(), exp_if_q.size(), exp_d_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
